uart_transmitter: RTL and testbench

UART transmit side for the FPGA serial link: accepts bytes over a valid/ready handshake and serialises them onto `Tx_o`. Frames are 8N1: one start bit, eight data bits LSB first, one stop bit, each lasting a fixed number of clock cycles derived from `FREQUENCY/SPEED`. A one-byte holding register lets the next byte be queued during a frame, so back-to-back frames go out with no idle gap. The block pairs with the UART receiver on the opposite end of the line.

---
 rtl/uart_transmitter.sv | 214 +++++++++++++++++++++
 tb/tb_uart_transmitter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
//
// Serialises bytes onto a UART line. The default frame is 8N1: start bit, eight
// data bits LSB first, stop bit. Every bit lasts DIVIDER = FREQUENCY/SPEED
// clock cycles, and DIVIDER must be at least 2. A one-byte holding register
// accepts the next byte while a frame is on the wire, so back-to-back frames go
// out with no idle gap.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even parity bit after
// data bit 7. The frame then becomes 8E1 and lasts 11*DIVIDER cycles.
//
// Ports:
//   CLK_i         in   system clock
//   Reset_i       in   synchronous active-high reset
//   data_i        in   [7:0] byte to send
//   data_valid_i  in   data_i is valid
//   ready_o       out  holding register empty; the byte is taken on an edge
//                      where data_valid_i && ready_o
//   busy_o        out  a frame is in progress (start through stop)
//   tx_done_o     out  one-cycle pulse in the last cycle of each stop bit
//   Tx_o          out  serial line, idles high
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module uart_transmitter #(
    parameter logic [31:0] FREQUENCY = 32'd50_000_000,
    parameter logic [31:0] SPEED     = 32'd9600
) (
    input  logic       CLK_i,
    input  logic       Reset_i,
    input  logic [7:0] data_i,
    input  logic       data_valid_i,
    output logic       ready_o,
    output logic       busy_o,
    output logic       tx_done_o,
    output logic       Tx_o
);

    localparam logic [31:0] DIVIDER   = FREQUENCY / SPEED;
    localparam logic [31:0] BAUD_LAST = DIVIDER - 32'd1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] baud_reg, baud_next;
    logic [2:0]  bit_cnt_reg, bit_cnt_next;
    logic [7:0]  shift_reg, shift_next;
    logic [7:0]  hold_reg, hold_next;
    logic        hold_full_reg, hold_full_next;
    logic        tx_reg, tx_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic        ready_reg, ready_next;
`ifdef UART_TX_PARITY_EN
    logic        parity_reg, parity_next;
`endif

    logic        bit_end;
    logic        load;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK_i) begin
        if (Reset_i) begin
            state_reg     <= ST_IDLE;
            baud_reg      <= 32'd0;
            bit_cnt_reg   <= 3'd0;
            shift_reg     <= 8'd0;
            hold_reg      <= 8'd0;
            hold_full_reg <= 1'b0;
            tx_reg        <= 1'b1;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            ready_reg     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_reg    <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            baud_reg      <= baud_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            hold_reg      <= hold_next;
            hold_full_reg <= hold_full_next;
            tx_reg        <= tx_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            ready_reg     <= ready_next;
`ifdef UART_TX_PARITY_EN
            parity_reg    <= parity_next;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic. The outputs are derived from the *next* state so that
    // the registered outputs line up with the state they describe.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        baud_next      = baud_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        hold_next      = hold_reg;
        hold_full_next = hold_full_reg;
        load           = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next    = parity_reg;
`endif

        bit_end = (baud_reg == BAUD_LAST);

        // The baud counter runs freely inside a frame. It wraps at each bit end,
        // so a new frame entered from STOP also starts from 0.
        if (state_reg == ST_IDLE) begin
            baud_next = 32'd0;
        end else if (bit_end) begin
            baud_next = 32'd0;
        end else begin
            baud_next = baud_reg + 32'd1;
        end

        unique case (state_reg)
            ST_IDLE: begin
                if (hold_full_reg) begin
                    load       = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_next   = ST_DATA;
                    bit_cnt_next = 3'd0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_next   = {1'b0, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_next = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    // A queued byte chains straight into the next start bit.
                    if (hold_full_reg) begin
                        load       = 1'b1;
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // A transfer needs a full holding register and an accept needs an empty
        // one, so the two can never happen in the same cycle.
        if (load) begin
            shift_next     = hold_reg;
            hold_full_next = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_next    = ^hold_reg;
`endif
        end else if (data_valid_i && !hold_full_reg) begin
            hold_next      = data_i;
            hold_full_next = 1'b1;
        end

        unique case (state_next)
            ST_START: tx_next = 1'b0;
            ST_DATA:  tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_next = parity_next;
`endif
            default:  tx_next = 1'b1;
        endcase

        busy_next  = (state_next != ST_IDLE);
        done_next  = (state_next == ST_STOP) && (baud_next == BAUD_LAST);
        ready_next = !hold_full_next;
    end

    assign Tx_o      = tx_reg;
    assign busy_o    = busy_reg;
    assign tx_done_o = done_reg;
    assign ready_o   = ready_reg;

endmodule

// File: tb/tb_uart_transmitter.sv
`timescale 1ns/1ps
module tb_uart_transmitter;

    localparam int D  = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int L  = NB * D;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = 8'h00;
    logic       valid = 1'b0;
    logic       ready, busy, done, tx;

    always #5 clk = ~clk;

    uart_transmitter #(.FREQUENCY(32'd160), .SPEED(32'd10)) dut (
        .CLK_i(clk), .Reset_i(rst), .data_i(data), .data_valid_i(valid),
        .ready_o(ready), .busy_o(busy), .tx_done_o(done), .Tx_o(tx)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit model_valid = 1'b0;

    // Behavioural model: a frame is "byte b started at edge t0"; the line level
    // at any later edge is just the bit (edge - t0)/D of the frame.
    bit         m_active = 1'b0;
    int         m_t0 = 0;
    logic [7:0] m_byte = 8'h00;
    bit         m_hold_full = 1'b0;
    logic [7:0] m_hold = 8'h00;
    bit         m_was_full, m_acc;
    int         m_e;
    int         accepts = 0;
    int         frames_done = 0;
    logic       e_tx = 1'b1, e_ready = 1'b1, e_busy = 1'b0, e_done = 1'b0;
    logic [7:0] exp_q[$];
    bit         dec_abort = 1'b0;

    // Decoder of the DUT line
    bit          dec_active = 1'b0;
    int          dec_start = 0, dec_off, dec_k;
    logic [NB-1:0] dec_bits;
    logic [7:0]  dec_byte, dec_exp;
    int          dec_count = 0, count_3c = 0;
    logic [7:0]  last_decoded = 8'h00;

`ifdef UART_TX_PARITY_EN
    int a5_seq [NB] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
    int a5_seq [NB] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
`endif

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        else if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        else if (k == 9) return ^b;
`endif
        else return 1'b1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h want 0x%0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_start();
        m_active    = 1'b1;
        m_t0        = cyc;
        m_byte      = m_hold;
        m_hold_full = 1'b0;
        exp_q.push_back(m_hold);
    endtask

    // Reference model, advanced on every rising edge
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
        if (rst) begin
            m_active    = 1'b0;
            m_hold_full = 1'b0;
            exp_q.delete();
            dec_abort   = 1'b1;
        end else begin
            m_was_full = m_hold_full;
            m_acc      = valid && !m_hold_full;
            if (m_active) begin
                if (cyc - m_t0 == L) begin
                    m_active = 1'b0;
                    frames_done++;
                    if (m_was_full) model_start();
                end
            end else if (m_was_full) begin
                model_start();
            end
            if (m_acc) begin
                m_hold      = data;
                m_hold_full = 1'b1;
                accepts++;
            end
        end
        if (m_active) begin
            m_e    = cyc - m_t0;
            e_tx   = frame_bit(m_byte, m_e / D);
            e_busy = 1'b1;
            e_done = (m_e == L - 1);
        end else begin
            e_tx   = 1'b1;
            e_busy = 1'b0;
            e_done = 1'b0;
        end
        e_ready     = !m_hold_full;
        model_valid = 1'b1;
    end

    // Per-cycle compare, away from the active edge
    initial forever begin
        @(negedge clk);
        if (model_valid) begin
            check("tx", tx, e_tx);
            check("ready", ready, e_ready);
            check("busy", busy, e_busy);
            check("tx_done", done, e_done);
        end
    end

    // Line decoder: samples each bit mid-way and matches whole frames
    initial forever begin
        @(negedge clk);
        if (dec_abort) begin
            dec_active = 1'b0;
            dec_abort  = 1'b0;
        end else if (!dec_active) begin
            if (model_valid && tx === 1'b0) begin
                dec_active = 1'b1;
                dec_start  = cyc;
            end
        end else begin
            dec_off = cyc - dec_start;
            if (dec_off % D == D / 2) begin
                dec_k = dec_off / D;
                dec_bits[dec_k] = tx;
                if (dec_k == NB - 1) begin
                    dec_active = 1'b0;
                    dec_byte   = dec_bits[8:1];
                    check("stop_bit", dec_bits[NB-1], 1);
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_frame: got byte 0x%02h, none queued", dec_byte);
                    end else begin
                        dec_exp = exp_q.pop_front();
                        check("frame_byte", dec_byte, dec_exp);
`ifdef UART_TX_PARITY_EN
                        check("parity_bit", dec_bits[9], ^dec_exp);
`endif
                    end
                    dec_count++;
                    if (dec_byte == 8'h3C) count_3c++;
                    last_decoded = dec_byte;
                end
            end
        end
    end

    // Offer a byte from a negedge; returns the edge at which it was taken.
    task automatic offer(input logic [7:0] b, output int acc_edge);
        int   waited;
        logic was_ready;
        data     = b;
        valid    = 1'b1;
        waited   = 0;
        acc_edge = -1;
        while (acc_edge < 0 && waited < 2000) begin
            was_ready = ready;
            @(posedge clk);
            @(negedge clk);
            waited++;
            if (was_ready === 1'b1) acc_edge = cyc;
        end
        valid = 1'b0;
        if (acc_edge < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: byte 0x%02h not taken within %0d cycles, want accept", b, waited);
        end
    endtask

    task automatic wait_edge(input int x);
        while (cyc < x) @(negedge clk);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((m_active || m_hold_full) && w < 5000) begin
            @(negedge clk);
            w++;
        end
        repeat (4) @(negedge clk);
    endtask

    int n, n2, s, a0, c0, gap;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset then idle
        repeat (100) @(negedge clk);
        check("idle_tx", tx, 1);
        check("idle_ready", ready, 1);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);

        // Single 0xA5 with hand-computed bit sequence and pulse timing
        offer(8'hA5, n);
        check("a5_ready_low", ready, 0);
        s = n + 1;
        for (int k = 0; k < NB; k++) begin
            wait_edge(s + D * k + D / 2);
            check("a5_bit", tx, a5_seq[k]);
        end
        wait_edge(n + L - 1);
        check("a5_done_early", done, 0);
        wait_edge(n + L);
        check("a5_done", done, 1);
        check("a5_busy_end", busy, 1);
        wait_edge(n + L + 1);
        check("a5_busy_fall", busy, 0);
        check("a5_done_fall", done, 0);
        drain();

`ifdef UART_TX_PARITY_EN
        offer(8'h07, n);
        wait_edge(n + 1 + 9 * D + D / 2);
        check("p07_parity", tx, 1);
        drain();
`endif

        // Back-to-back 0x00 then 0xFF, second offered during DATA
        offer(8'h00, n);
        s = n + 1;
        wait_edge(s + 40);
        offer(8'hFF, n2);
        check("b2b_accept_edge", n2, s + 41);
        check("b2b_ready_low", ready, 0);
        wait_edge(s + L - 1);
        check("b2b_stop_tx", tx, 1);
        check("b2b_stop_done", done, 1);
        check("b2b_ready_wait", ready, 0);
        wait_edge(s + L);
        check("b2b_second_start", tx, 0);
        check("b2b_busy", busy, 1);
        check("b2b_ready_back", ready, 1);
        drain();
        check("b2b_last_byte", last_decoded, 8'hFF);

        // Accept coinciding with the end of STOP on an empty holding register
        offer(8'h12, n);
        s = n + 1;
        wait_edge(s + L - 1);
        offer(8'h34, n2);
        check("stopacc_edge", n2, s + L);
        check("stopacc_idle_tx", tx, 1);
        check("stopacc_idle_busy", busy, 0);
        wait_edge(s + L + 1);
        check("stopacc_start", tx, 0);
        drain();

        // Backpressure: valid held high with 0x3C
        a0 = accepts;
        c0 = count_3c;
        data  = 8'h3C;
        valid = 1'b1;
        repeat (3 * L) @(negedge clk);
        valid = 1'b0;
        drain();
        check("bp_accepts", accepts - a0, 4);
        check("bp_frames", count_3c - c0, accepts - a0);

        // Mid-frame reset during data bit 3 of 0x55
        offer(8'h55, n);
        s = n + 1;
        wait_edge(s + 4 * D + 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_ready", ready, 1);
        repeat (200) @(negedge clk);
        a0 = dec_count;
        offer(8'h81, n);
        drain();
        check("post_rst_frames", dec_count - a0, 1);
        check("post_rst_byte", last_decoded, 8'h81);

        // Randomized traffic with random gaps (including zero)
        for (int i = 0; i < 12; i++) begin
            gap = $urandom_range(0, 2 * L);
            repeat (gap) @(negedge clk);
            offer(8'($urandom), n);
        end
        drain();

        check("total_frames", dec_count, frames_done);
        check("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
